// File: rtl/hit_seq_pkg.sv
// Shared types and constants for the hit cluster sequencer.
// Strip count is fixed at 128, which gives a 7-bit strip address.
package hit_seq_pkg;

  localparam int HS_NSTRIP = 128;
  localparam int HS_ADDR_W = 7;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_SCAN,
    HS_DONE
  } hs_state_t;

  typedef struct packed {
    logic [HS_ADDR_W-1:0] addr;
    logic [2:0]           next;
  } hs_cluster_t;

  // Bits still worth keeping once the cluster at strip a is consumed.
  // Nothing above a is set, so the result is simply every strip below a-3.
  function automatic logic [HS_NSTRIP-1:0] hs_keep_mask(input logic [HS_ADDR_W-1:0] a);
    if (a >= HS_ADDR_W'(3))
      hs_keep_mask = ~({HS_NSTRIP{1'b1}} << (a - HS_ADDR_W'(3)));
    else
      hs_keep_mask = '0;
  endfunction

endpackage

// File: rtl/hit_prio_enc.sv
// Combinational priority encoder: index of the highest set bit of a 128-bit vector.
// Built as a balanced binary tree, so the depth is log2(128) = 7 two-input stages.
module hit_prio_enc
  import hit_seq_pkg::*;
(
  input  logic [HS_NSTRIP-1:0] vec,
  output logic [HS_ADDR_W-1:0] idx,
  output logic                 none
);

  // Heap-ordered tree: node n has children 2n (lower strips) and 2n+1 (upper strips).
  // Leaves sit at HS_NSTRIP+b for strip b; the root is node 1.
  logic                 node_v [1:2*HS_NSTRIP-1];
  logic [HS_ADDR_W-1:0] node_i [1:2*HS_NSTRIP-1];

  always_comb begin
    for (int b = 0; b < HS_NSTRIP; b++) begin
      node_v[HS_NSTRIP+b] = vec[b];
      node_i[HS_NSTRIP+b] = HS_ADDR_W'(b);
    end
    for (int n = HS_NSTRIP-1; n >= 1; n--) begin
      node_v[n] = node_v[2*n+1] | node_v[2*n];
      node_i[n] = node_v[2*n+1] ? node_i[2*n+1] : node_i[2*n];
    end
  end

  assign idx  = node_i[1];
  assign none = ~node_v[1];

endmodule

// File: rtl/hit_cluster_seq.sv
// Drains a latched 128-strip hit pattern one cluster per handshake, highest strip first,
// with a per-event cluster limit. Optional input mask enabled by HIT_SEQ_MASK_EN.
module hit_cluster_seq
  import hit_seq_pkg::*;
#(
  parameter int NSTRIP       = HS_NSTRIP,
  parameter int MAX_CLUSTERS = 64
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 load_i,
  input  logic [NSTRIP-1:0]    data_i,
`ifdef HIT_SEQ_MASK_EN
  input  logic [NSTRIP-1:0]    mask_i,
`endif
  output logic                 busy_o,
  output logic                 hit_valid_o,
  input  logic                 hit_ready_i,
  output logic [HS_ADDR_W-1:0] hit_addr_o,
  output logic [2:0]           next_bits_o,
  output logic                 done_o,
  output logic                 overflow_o,
  output logic [7:0]           count_o
);

  localparam logic [7:0] MAX_C = 8'(MAX_CLUSTERS);

  hs_state_t             state_q, state_d;
  logic [HS_NSTRIP-1:0]  pat_q;
  logic [7:0]            cnt_q;
  logic                  ovf_q;

  logic [HS_ADDR_W-1:0]  top_addr;
  logic                  pat_none;
  logic [HS_NSTRIP-1:0]  load_pat;
  logic [HS_NSTRIP-1:0]  pat_post;
  logic [7:0]            cnt_post;
  logic                  handshake;
  logic                  scan_exit;
  logic [HS_NSTRIP+2:0]  pat_ext;
  logic [7:0]            ext_idx;
  hs_cluster_t           cluster;

`ifdef HIT_SEQ_MASK_EN
  assign load_pat = data_i & ~mask_i;
`else
  assign load_pat = data_i;
`endif

  hit_prio_enc u_enc (
    .vec  (pat_q),
    .idx  (top_addr),
    .none (pat_none)
  );

  // Three zero bits below strip 0 make out-of-range neighbours read as 0.
  assign pat_ext      = {pat_q, 3'b000};
  assign ext_idx      = {1'b0, top_addr};
  assign cluster.addr = top_addr;
  assign cluster.next = {pat_ext[ext_idx + 8'd2], pat_ext[ext_idx + 8'd1], pat_ext[ext_idx]};
  assign hit_addr_o   = cluster.addr;
  assign next_bits_o  = cluster.next;
  assign count_o      = cnt_q;

  // Post-handshake view of the datapath; SCAN exit is judged on these values.
  assign handshake = hit_valid_o & hit_ready_i;
  assign pat_post  = handshake ? (pat_q & hs_keep_mask(top_addr)) : pat_q;
  assign cnt_post  = handshake ? (cnt_q + 8'd1) : cnt_q;
  assign scan_exit = (pat_post == '0) || (cnt_post == MAX_C);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= HS_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first, so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      HS_IDLE: if (load_i)    state_d = HS_SCAN;
      HS_SCAN: if (scan_exit) state_d = HS_DONE;
      HS_DONE:                state_d = HS_IDLE;
      default:                state_d = HS_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != HS_IDLE);
    hit_valid_o = (state_q == HS_SCAN) && !pat_none && (cnt_q < MAX_C);
    done_o      = (state_q == HS_DONE);
    overflow_o  = (state_q == HS_DONE) && ovf_q;
  end

  // NOTE: the 128-bit pattern register is reset as well: address and neighbour
  // outputs decode straight from it and must read 0 right after reset.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pat_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        HS_IDLE: if (load_i) begin
          pat_q <= load_pat;
          cnt_q <= '0;
          ovf_q <= 1'b0;
        end
        HS_SCAN: begin
          pat_q <= pat_post;
          cnt_q <= cnt_post;
          if (scan_exit) ovf_q <= (pat_post != '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hit_cluster_seq.sv
// Self-checking bench for hit_cluster_seq: reference model feeds a scoreboard,
// a negedge monitor pops and compares every accepted cluster and every done pulse.
module tb_hit_cluster_seq;
  import hit_seq_pkg::*;

  localparam int MAX_C = 4;

  typedef struct packed {
    logic [7:0] cnt;
    logic       ovf;
  } done_exp_t;

  logic         clk = 1'b0;
  logic         rstb;
  logic         load_i;
  logic [127:0] data_i;
  logic [127:0] mask_i;
  logic         busy_o, hit_valid_o, hit_ready_i, done_o, overflow_o;
  logic [6:0]   hit_addr_o;
  logic [2:0]   next_bits_o;
  logic [7:0]   count_o;

  int n_vec = 0;
  int n_err = 0;
  int rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low

  hs_cluster_t exp_cl[$];
  done_exp_t   exp_done[$];

  hit_cluster_seq #(.MAX_CLUSTERS(MAX_C)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .load_i      (load_i),
    .data_i      (data_i),
`ifdef HIT_SEQ_MASK_EN
    .mask_i      (mask_i),
`endif
    .busy_o      (busy_o),
    .hit_valid_o (hit_valid_o),
    .hit_ready_i (hit_ready_i),
    .hit_addr_o  (hit_addr_o),
    .next_bits_o (next_bits_o),
    .done_o      (done_o),
    .overflow_o  (overflow_o),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: repeatedly take the highest hit, report its three lower neighbours,
  // then wipe that strip and the three below it, until empty or the limit is hit.
  task automatic model_push(input logic [127:0] pat, output int n);
    logic [127:0] p;
    hs_cluster_t  cl;
    done_exp_t    de;
    p = pat;
    n = 0;
    while (p != '0 && n < MAX_C) begin
      int a;
      a = 127;
      while (!p[a]) a--;
      cl.addr = 7'(a);
      for (int j = 1; j <= 3; j++) cl.next[3-j] = (a - j >= 0) ? p[a-j] : 1'b0;
      exp_cl.push_back(cl);
      for (int j = 0; j <= 3; j++) if (a - j >= 0) p[a-j] = 1'b0;
      n++;
    end
    de.cnt = 8'(n);
    de.ovf = (p != '0);
    exp_done.push_back(de);
  endtask

  initial begin
    hit_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       hit_ready_i = 1'b1;
        1:       hit_ready_i = 1'($urandom_range(0, 1));
        default: hit_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted cluster and every done pulse.
  logic       prev_stall = 1'b0;
  logic [6:0] prev_addr;
  logic [2:0] prev_next;

  always @(negedge clk) begin
    if (!rstb) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(hit_valid_o), 32'd1);
        check("stall_addr", 32'(hit_addr_o), 32'(prev_addr));
        check("stall_next", 32'(next_bits_o), 32'(prev_next));
      end
      if (hit_valid_o && hit_ready_i) begin
        if (exp_cl.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL cluster_unexpected: got addr %0d, none expected", hit_addr_o);
        end else begin
          hs_cluster_t e;
          e = exp_cl.pop_front();
          check("cluster_addr", 32'(hit_addr_o), 32'(e.addr));
          check("cluster_next", 32'(next_bits_o), 32'(e.next));
        end
      end
      if (done_o) begin
        if (exp_done.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL done_unexpected: got done_o=1, none expected");
        end else begin
          done_exp_t d;
          d = exp_done.pop_front();
          check("done_count", 32'(count_o), 32'(d.cnt));
          check("done_overflow", 32'(overflow_o), 32'(d.ovf));
          check("done_no_valid", 32'(hit_valid_o), 32'd0);
        end
      end
      prev_stall = hit_valid_o && !hit_ready_i;
      prev_addr  = hit_addr_o;
      prev_next  = next_bits_o;
    end
  end

  task automatic run_event(input logic [127:0] pat, input bit timed, input bit glitch);
    int n, c;
    bit got;
    check("idle_before_load", 32'(busy_o), 32'd0);
    model_push(pat & ~mask_i, n);
    @(posedge clk); #1;
    data_i = pat; load_i = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
    c = 0; got = 1'b0;
    while (!got && c < 400) begin
      @(negedge clk);
      c++;
      if (done_o) got = 1'b1;
      @(posedge clk); #1;
      if (glitch && c == 1) begin
        load_i = 1'b1;
        data_i = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        load_i = 1'b0;
      end
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: got no done_o within %0d cycles, expected one", c);
    end else if (timed) begin
      check("done_latency", 32'(c), 32'(1 + ((n > 0) ? n : 1)));
    end
    @(negedge clk);
    check("idle_after_done", 32'(busy_o), 32'd0);
    check("done_one_cycle", 32'(done_o), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_valid"}, 32'(hit_valid_o), 32'd0);
    check({tag, "_addr"}, 32'(hit_addr_o), 32'd0);
    check({tag, "_next"}, 32'(next_bits_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_ovf"}, 32'(overflow_o), 32'd0);
    check({tag, "_count"}, 32'(count_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] p;
    rstb = 1'b0; load_i = 1'b0; data_i = '0; mask_i = '0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(posedge clk);

    // Directed cases, ready held high so latency is exact.
    p = '0; p[127] = 1; p[126] = 1; p[124] = 1; p[3] = 1;
    run_event(p, 1'b1, 1'b0);
    p = '0; p[2] = 1; p[1] = 1; p[0] = 1;
    run_event(p, 1'b1, 1'b0);
    run_event('0, 1'b1, 1'b0);
    p = '0;
    for (int i = 0; i < 128; i += 8) p[i] = 1'b1;
    run_event(p, 1'b1, 1'b0);
    p = '0; p[127] = 1; p[0] = 1;
    run_event(p, 1'b1, 1'b1);

`ifdef HIT_SEQ_MASK_EN
    mask_i = '0; mask_i[127] = 1'b1;
    p = '0; p[127] = 1; p[5] = 1;
    run_event(p, 1'b1, 1'b0);
    mask_i = '0;
`endif

    // Random patterns with random ready stalls and stray loads during SCAN.
    rdy_mode = 1;
    for (int e = 0; e < 40; e++) begin
      if ($urandom_range(0, 3) == 0) begin
        p = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        p = '0;
        repeat ($urandom_range(0, 9)) p[$urandom_range(0, 127)] = 1'b1;
      end
      run_event(p, 1'b0, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a stalled SCAN.
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    p = '0; p[100] = 1; p[50] = 1; p[10] = 1;
    @(posedge clk); #1;
    data_i = p; load_i = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
    @(negedge clk);
    check("pre_reset_valid", 32'(hit_valid_o), 32'd1);
    check("pre_reset_addr", 32'(hit_addr_o), 32'd100);
    @(posedge clk); #3;
    rstb = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    p = '0; p[64] = 1; p[62] = 1; p[9] = 1;
    run_event(p, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    check("sb_drain_clusters", 32'(exp_cl.size()), 32'd0);
    check("sb_drain_done", 32'(exp_done.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hit_cluster_seq.md
# hit_cluster_seq

Sequencer that drains a latched 128-strip hit pattern one cluster per accepted handshake, scanning from strip 127 downward. Each cluster is the highest remaining hit address plus a 3-bit map of the three strips below it. It sits between the front-end hit register and the packet builder, and it owns the priority encoder that locates hits. It also enforces a per-event cluster limit and reports overflow.

## Interface

- `NSTRIP`, default 128: strips per pattern; fixed at 128 (address width 7).
- `MAX_CLUSTERS`, default 64: cluster limit per event; legal range 1..128.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rstb`  in  1: reset, asynchronous assert, active-low.
- `load_i`  in  1: load strobe; accepted only in IDLE.
- `data_i`  in  128: hit pattern; sampled when `load_i` is accepted.
- `busy_o`  out  1: high in any state other than IDLE.
- `hit_valid_o`  out  1: a cluster is presented.
- `hit_ready_i`  in  1: consumer accepts the presented cluster.
- `hit_addr_o`  out  7: highest remaining hit strip.
- `next_bits_o`  out  3: bits [2:0] are pattern[addr-1], [addr-2], [addr-3]; a bit is 0 where its index is below 0.
- `done_o`  out  1: one-cycle end-of-event pulse.
- `overflow_o`  out  1: hits remained at the limit; valid while `done_o` is high.
- `count_o`  out  8: clusters accepted in the current event.

## Operation

- Three-state FSM.
  - IDLE: wait for load.
  - SCAN: present clusters.
  - DONE: end of event.
- Internal registers: `pat_q[127:0]`, `cnt_q[7:0]`, `ovf_q`.
- IDLE, on `load_i`=1:
  - `pat_q` <= `data_i`, `cnt_q` <= 0, `ovf_q` <= 0.
  - Go to SCAN.
- IDLE, on `load_i`=0: stay in IDLE.
- SCAN outputs:
  - Encoder A = highest set bit of `pat_q`.
  - `hit_valid_o` = (`pat_q`!=0) && (`cnt_q`<MAX_CLUSTERS).
  - `hit_addr_o` = A; `next_bits_o` as defined in Interface.
- SCAN, on handshake (valid && ready):
  - Clear `pat_q` bits A, A-1, A-2, A-3; clamp at bit 0 and leave negative indices alone.
  - `cnt_q` <= `cnt_q`+1.
- SCAN exit, evaluated each cycle on the post-update values:
  - Exit when `pat_q`==0, or when `cnt_q`==MAX_CLUSTERS.
  - `ovf_q` <= (`pat_q`!=0) at exit; go to DONE.
- DONE:
  - `done_o`=1 and `overflow_o`=`ovf_q` for exactly one cycle.
  - Go to IDLE.
- `load_i` is ignored in SCAN and DONE; no queueing.
- `hit_ready_i` is ignored while `hit_valid_o`=0.
- Presented values stay stable while valid && !ready.
- `count_o` = `cnt_q`. It holds its value through IDLE until the next load.

## Timing

- Reset values of all outputs and registers: 0; state IDLE.
- Reset mid-event aborts immediately. No `done_o` is issued, and the pattern is discarded.
- Latency: load accepted at edge k; first `hit_valid_o` in cycle k+1.
- Throughput: one cluster per cycle while ready is held high.
- Exit timing: the handshake that empties the pattern or reaches the limit at edge m gives state DONE in cycle m+1. `done_o` is high in cycle m+1 and IDLE follows in cycle m+2.
- Empty load: SCAN lasts one cycle with valid=0. DONE is in cycle k+2 with `overflow_o`=0.
- Outputs `hit_addr_o` and `next_bits_o` are combinational from `pat_q`. `hit_valid_o`, `busy_o`, `done_o` and `overflow_o` decode from registered state.
- Back-to-back events: the earliest next load is at the edge where the block is in IDLE, which is cycle m+2.

## Configuration

- `HIT_SEQ_MASK_EN` defined:
  - Adds input `mask_i[127:0]`.
  - The pattern is loaded as `data_i & ~mask_i`, so masked strips never produce clusters and are never counted as overflow.
- Undefined: no `mask_i` port, and `data_i` is loaded unmodified.

## Structure

- Package `hit_seq_pkg` holds:
  - `HS_NSTRIP`=128 and `HS_ADDR_W`=7.
  - State enum `hs_state_t` {HS_IDLE, HS_SCAN, HS_DONE}.
  - Cluster struct `hs_cluster_t` {addr[6:0], next[2:0]}.
- Sub-module `hit_prio_enc`, purely combinational:
  - 128-bit input; outputs highest-set-bit index [6:0] and flag `none`.
  - Implemented as a log-depth tree, not a linear ternary chain.
- The top level holds the FSM, pattern register, clear logic and counter.

## Test plan

- Pattern bits {127,126,124,3}, ready tied to 1. Required response:
  - Cluster (127,3'b101), then cluster (3,3'b000).
  - `done_o` at k+3, `count_o`=2, `overflow_o`=0.
- Pattern bits {2,1,0}: one cluster (2,3'b110); bit positions below 0 read as 0.
- All-zero load: no valid; `done_o` at k+2; `overflow_o`=0; `count_o`=0.
- MAX_CLUSTERS=4, pattern of every 8th strip (16 hits): exactly 4 clusters (120,112,104,96), then `done_o` with `overflow_o`=1.
- Random ready stalls: addr and next bits stay stable while stalled. A `load_i` pulse during SCAN is ignored, and the cluster sequence is unchanged.
- `rstb` low mid-SCAN: all outputs 0 asynchronously. After release, a new load works normally.
- With `HIT_SEQ_MASK_EN`: mask bit 127 on pattern {127,5} gives the single cluster (5,3'b000).
